// File: rtl/x25519_finalize.sv
// x25519_finalize: converts the projective ladder result {z, x} into affine x.
// Computes x * z^(p-2) mod p, p = 2^255-19, by square-and-multiply through a
// shared external GF(p) multiplier (one request outstanding at a time).
// The op sequence is fixed (254 squares, 252 multiplies, 1 final), so the
// latency is independent of the operand values.
module x25519_finalize (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [511:0] work_in,
  output logic         busy,
  output logic         out_valid,
  output logic [255:0] work_out,
  output logic         mult_en,
  output logic [255:0] mult_a,
  output logic [255:0] mult_b,
  input  logic         mult_valid,
  input  logic [255:0] mult_out
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;
  typedef enum logic [1:0] {OP_SQ, OP_MUL, OP_FIN} op_t;

  // Exponent p-2 = 2^255-21: bits 254..0 set except bits 4 and 2.
  function automatic logic ebit(input logic [7:0] idx);
    return !((idx == 8'd4) || (idx == 8'd2));
  endfunction

  state_t       state, state_nxt;
  op_t          phase, phase_nxt;
  logic [7:0]   bit_i, bit_i_nxt;
  logic         op_load;
  logic [255:0] a_nxt, b_nxt;
  logic [255:0] x_r, z_r, acc;

  // Handshake outputs decode directly from the state register.
  assign busy    = (state != S_IDLE);
  assign mult_en = (state == S_ISSUE);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic and selection of the next multiplier operands.
  always_comb begin
    state_nxt = state;
    phase_nxt = phase;
    bit_i_nxt = bit_i;
    op_load   = 1'b0;
    a_nxt     = mult_a;
    b_nxt     = mult_b;
    unique case (state)
      S_IDLE: begin
        if (en) begin
          // acc starts as z (exponent bit 254); first op squares it for bit 253.
          state_nxt = S_ISSUE;
          op_load   = 1'b1;
          phase_nxt = OP_SQ;
          bit_i_nxt = 8'd253;
          a_nxt     = work_in[511:256];
          b_nxt     = work_in[511:256];
        end
      end
      S_ISSUE: state_nxt = S_WAIT;
      S_WAIT: begin
        if (mult_valid) begin
          if (phase == OP_FIN) begin
            state_nxt = S_DONE;
          end else begin
            state_nxt = S_ISSUE;
            op_load   = 1'b1;
            a_nxt     = mult_out;
            if ((phase == OP_SQ) && ebit(bit_i)) begin
              phase_nxt = OP_MUL;
              b_nxt     = z_r;
            end else if (bit_i == 8'd0) begin
              phase_nxt = OP_FIN;
              b_nxt     = x_r;
            end else begin
              phase_nxt = OP_SQ;
              bit_i_nxt = bit_i - 8'd1;
              b_nxt     = mult_out;
            end
          end
        end
      end
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Registered operands, op tracking and result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      mult_a    <= '0;
      mult_b    <= '0;
      phase     <= OP_SQ;
      bit_i     <= '0;
      out_valid <= 1'b0;
      work_out  <= '0;
    end else begin
      out_valid <= (state == S_DONE);
      if (state == S_DONE) work_out <= acc;
      if (op_load) begin
        mult_a <= a_nxt;
        mult_b <= b_nxt;
        phase  <= phase_nxt;
        bit_i  <= bit_i_nxt;
      end
    end
  end

  // Operand latch and running accumulator.
  always_ff @(posedge clk) begin
    if ((state == S_IDLE) && en) begin
      x_r <= work_in[255:0];
      z_r <= work_in[511:256];
      acc <= work_in[511:256];
    end else if ((state == S_WAIT) && mult_valid) begin
      acc <= mult_out;
    end
  end

endmodule

// File: tb/tb_x25519_finalize.sv
// Testbench for x25519_finalize: behavioural mod-p multiplier with
// configurable latency, op-shape scoreboard, table vectors and random runs.
module tb_x25519_finalize;

  localparam logic [255:0] P    = {1'b0, {255{1'b1}}} - 256'd18;
  localparam logic [255:0] HALF = (P + 256'd1) >> 1;
  localparam int K_SQ  = 0;
  localparam int K_MUL = 1;
  localparam int K_FIN = 2;
  localparam int NOPS  = 507;

  logic         clk = 1'b0;
  logic         rst, en;
  logic [511:0] work_in;
  logic         busy, out_valid;
  logic [255:0] work_out;
  logic         mult_en;
  logic [255:0] mult_a, mult_b;
  logic         mult_valid;
  logic [255:0] mult_out;

  always #5 clk = ~clk;

  x25519_finalize dut (
    .clk(clk), .rst(rst), .en(en), .work_in(work_in),
    .busy(busy), .out_valid(out_valid), .work_out(work_out),
    .mult_en(mult_en), .mult_a(mult_a), .mult_b(mult_b),
    .mult_valid(mult_valid), .mult_out(mult_out)
  );

  int total = 0;
  int passed = 0;
  int lat_cfg = 3;
  int cnt = 0;
  int op_idx = 0;
  int spur_op = -1;
  int sb_err = 0;
  string sb_msg;
  logic [255:0] exp_x, exp_z, exp_acc, cap_a, cap_b;
  int ops[$];

  typedef struct {
    logic [255:0] x;
    logic [255:0] z;
    int           lat;
    logic [255:0] expv;
  } vec_t;
  vec_t tbl[6];

  function automatic logic [255:0] mulmod(input logic [255:0] a, input logic [255:0] b);
    logic [511:0] t;
    t = {256'd0, a} * {256'd0, b};
    t = t % {256'd0, P};
    return t[255:0];
  endfunction

  function automatic logic [255:0] powmod(input logic [255:0] base_in, input logic [255:0] e_in);
    logic [255:0] r, b, e;
    r = 256'd1; b = base_in; e = e_in;
    while (e != 0) begin
      if (e[0]) r = mulmod(r, b);
      b = mulmod(b, b);
      e = e >> 1;
    end
    return r;
  endfunction

  function automatic logic [255:0] ref_affine(input logic [255:0] x, input logic [255:0] z);
    return mulmod(x, powmod(z, P - 256'd2));
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int k = 0; k < 8; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] expv);
    total++;
    if (act === expv) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, expv);
  endtask

  task automatic note_err(input string m);
    if (sb_err == 0) sb_msg = m;
    sb_err++;
  endtask

  // Behavioural multiplier plus request scoreboard, evaluated mid-cycle.
  always @(negedge clk) begin
    bit pending;
    int kind;
    mult_valid = 1'b0;
    if (rst) begin
      cnt = 0;
    end else begin
      pending = (cnt > 0);
      if (pending) begin
        if (mult_a !== cap_a || mult_b !== cap_b) note_err("operands moved while outstanding");
        cnt--;
        if (cnt == 0) begin
          mult_valid = 1'b1;
          mult_out   = mulmod(cap_a, cap_b);
          exp_acc    = mult_out;
        end
      end
      if (mult_en) begin
        if (pending) note_err($sformatf("request %0d while another outstanding", op_idx));
        if (op_idx >= NOPS) begin
          note_err($sformatf("extra request %0d", op_idx));
        end else begin
          kind = ops[op_idx];
          if (kind == K_SQ && (mult_a !== exp_acc || mult_b !== exp_acc))
            note_err($sformatf("op %0d square operands wrong", op_idx));
          if (kind == K_MUL && (mult_a !== exp_acc || mult_b !== exp_z))
            note_err($sformatf("op %0d multiply operands wrong", op_idx));
          if (kind == K_FIN && (mult_a !== exp_acc || mult_b !== exp_x))
            note_err($sformatf("op %0d final operands wrong", op_idx));
        end
        cap_a = mult_a;
        cap_b = mult_b;
        cnt   = lat_cfg;
        if (op_idx == spur_op) begin
          mult_valid = 1'b1;
          mult_out   = 256'hdead_beef;
        end
        op_idx++;
      end
    end
  end

  task automatic arm(input logic [255:0] x, input logic [255:0] z, input int lat, input int spur);
    exp_x   = x;
    exp_z   = z;
    exp_acc = z;
    lat_cfg = lat;
    op_idx  = 0;
    spur_op = spur;
    sb_err  = 0;
    sb_msg  = "";
  endtask

  task automatic run_op(input string name, input logic [255:0] x, input logic [255:0] z,
                        input int lat, input logic [255:0] expv, input int poke, input int spur);
    int cyc, limit;
    logic [255:0] held;
    arm(x, z, lat, spur);
    limit = 1 + NOPS * (lat + 1) + 1 + 50;
    @(negedge clk);
    work_in = {z, x};
    en = 1'b1;
    @(posedge clk); #1;
    en = 1'b0;
    work_in = ~{z, x};
    cyc = 1;
    chk({name, ".busy_rise"}, 256'(busy), 256'd1);
    while (!out_valid && cyc < limit) begin
      @(posedge clk); #1;
      cyc++;
      en = (cyc == poke);
      if (cyc == poke) work_in = {z ^ 256'h3c, x ^ 256'ha5};
    end
    en = 1'b0;
    chk({name, ".done"}, 256'(out_valid), 256'd1);
    chk({name, ".result"}, work_out, expv);
    chk({name, ".latency"}, 256'(cyc), 256'(1 + NOPS * (lat + 1) + 1));
    chk({name, ".busy_fall"}, 256'(busy), 256'd0);
    chk({name, ".req_count"}, 256'(op_idx), 256'(NOPS));
    if (sb_err != 0) $display("FAIL %s.scoreboard: %s", name, sb_msg);
    chk({name, ".op_errors"}, 256'(sb_err), 256'd0);
    held = work_out;
    @(posedge clk); #1;
    chk({name, ".pulse"}, 256'(out_valid), 256'd0);
    chk({name, ".held"}, work_out, held);
  endtask

  initial begin
    logic [255:0] rx, rz, res;
    int rl, guard;

    for (int i = 253; i >= 0; i--) begin
      ops.push_back(K_SQ);
      if (!(i == 4 || i == 2)) ops.push_back(K_MUL);
    end
    ops.push_back(K_FIN);

    tbl[0] = '{x: 256'd9, z: 256'd1, lat: 3, expv: 256'd9};
    tbl[1] = '{x: 256'd2, z: 256'd2, lat: 3, expv: 256'd1};
    tbl[2] = '{x: 256'd1, z: 256'd2, lat: 3, expv: HALF};
    tbl[3] = '{x: 256'd5, z: 256'd0, lat: 3, expv: 256'd0};
    tbl[4] = '{x: 256'd9, z: 256'd1, lat: 1, expv: 256'd9};
    tbl[5] = '{x: 256'd3, z: 256'd3, lat: 5, expv: 256'd1};

    rst = 1'b1; en = 1'b0; work_in = '0;
    mult_valid = 1'b0; mult_out = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset.busy", 256'(busy), 256'd0);
    chk("reset.out_valid", 256'(out_valid), 256'd0);
    chk("reset.mult_en", 256'(mult_en), 256'd0);
    chk("reset.work_out", work_out, 256'd0);
    chk("reset.mult_a", mult_a, 256'd0);
    #1 rst = 1'b0;

    for (int t = 0; t < 6; t++)
      run_op($sformatf("vec%0d", t), tbl[t].x, tbl[t].z, tbl[t].lat, tbl[t].expv, -1, -1);

    // en during busy with other operands, plus a stray mult_valid in ISSUE.
    run_op("ignore", 256'd11, 256'd7, 1, ref_affine(256'd11, 256'd7), 10, 0);

    for (int r = 0; r < 3; r++) begin
      rx = rand256() % P;
      rz = rand256() % P;
      if (rz == 0) rz = 256'd1;
      rl = ($urandom_range(0, 1) != 0) ? 5 : 1;
      run_op($sformatf("rand%0d", r), rx, rz, rl, ref_affine(rx, rz), -1, -1);
      res = work_out;
      chk($sformatf("rand%0d.inverse", r), mulmod(res, rz), rx);
    end

    // Reset mid-run at op 200.
    arm(256'd4, 256'd5, 3, -1);
    @(negedge clk);
    work_in = {256'd5, 256'd4};
    en = 1'b1;
    @(posedge clk); #1;
    en = 1'b0;
    guard = 0;
    while (op_idx < 200 && guard < 2000) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("midrst.reached", 256'(op_idx >= 200), 256'd1);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst.busy", 256'(busy), 256'd0);
    chk("midrst.out_valid", 256'(out_valid), 256'd0);
    chk("midrst.mult_en", 256'(mult_en), 256'd0);
    chk("midrst.work_out", work_out, 256'd0);
    chk("midrst.mult_b", mult_b, 256'd0);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    run_op("after_rst", 256'd9, 256'd3, 1, ref_affine(256'd9, 256'd3), -1, -1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
